// File: rtl/clock_time_core.sv
// Time-keeping and alarm engine: BCD HH:MM:SS counter, alarm HH:MM register,
// button adjust, alarm compare/timeout and registered 4-digit display feed.
module clock_time_core #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned ALARM_LEN_SEC = 60
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] mode,
  input  logic       min_up,
  input  logic       hour_up,
  input  logic       alarm_en,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       colon,
  output logic       sec_tick,
  output logic       alarm
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned AW = $clog2(ALARM_LEN_SEC + 1);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_LEN_SEC - 1);

  typedef enum logic [1:0] {
    RUN_HM    = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2,
    RUN_MS    = 2'd3
  } mode_e;

  mode_e         md;
  logic [PW-1:0] cnt;
  logic [7:0]    hh, mm, ss;
  logic [7:0]    ahh, amm;
  logic          min_prev, hour_prev;
  logic [AW-1:0] alarm_cnt;
  logic          tick_c, min_rise_c, hour_rise_c, run_mode_c, alarm_hit_c;

  // BCD pair increment that wraps to 00 after max
  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Decoded mode, second strobe, button edges and alarm match
  always_comb begin
    md          = mode_e'(mode);
    tick_c      = (cnt == TERM) && (md != SET_TIME);
    min_rise_c  = min_up & ~min_prev;
    hour_rise_c = hour_up & ~hour_prev;
    run_mode_c  = (md == RUN_HM) || (md == RUN_MS);
    alarm_hit_c = sec_tick && alarm_en && (md != SET_TIME) &&
                  (ss == 8'h00) && (hh == ahh) && (mm == amm);
  end

  // Prescaler, held at zero while the time is being set
  always_ff @(posedge clk) begin
    if (clr || md == SET_TIME || cnt == TERM)
      cnt <= '0;
    else
      cnt <= cnt + PW'(1);
  end

  // Button history for rising-edge detection
  always_ff @(posedge clk) begin
    if (clr) begin
      min_prev  <= 1'b0;
      hour_prev <= 1'b0;
    end else begin
      min_prev  <= min_up;
      hour_prev <= hour_up;
    end
  end

  // Time of day: manual adjust in SET_TIME, otherwise advance once per second
  always_ff @(posedge clk) begin
    if (clr) begin
      hh <= 8'h00;
      mm <= 8'h00;
      ss <= 8'h00;
    end else if (md == SET_TIME) begin
      if (min_rise_c) begin
        mm <= inc_bcd(mm, 8'h59);
        ss <= 8'h00;
      end
      if (hour_rise_c)
        hh <= inc_bcd(hh, 8'h23);
    end else if (tick_c) begin
      ss <= inc_bcd(ss, 8'h59);
      if (ss == 8'h59) begin
        mm <= inc_bcd(mm, 8'h59);
        if (mm == 8'h59)
          hh <= inc_bcd(hh, 8'h23);
      end
    end
  end

  // Alarm HH:MM register, adjusted only in SET_ALARM
  always_ff @(posedge clk) begin
    if (clr) begin
      ahh <= 8'h00;
      amm <= 8'h00;
    end else if (md == SET_ALARM) begin
      if (min_rise_c)
        amm <= inc_bcd(amm, 8'h59);
      if (hour_rise_c)
        ahh <= inc_bcd(ahh, 8'h23);
    end
  end

  // Alarm: fires the cycle after the matching second, ends on timeout, disarm or dismiss
  always_ff @(posedge clk) begin
    if (clr) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else if (alarm) begin
      if (!alarm_en || (run_mode_c && (min_rise_c || hour_rise_c)))
        alarm <= 1'b0;
      else if (sec_tick) begin
        if (alarm_cnt == ALARM_LAST)
          alarm <= 1'b0;
        else
          alarm_cnt <= alarm_cnt + AW'(1);
      end
    end else if (alarm_hit_c) begin
      alarm     <= 1'b1;
      alarm_cnt <= '0;
    end
  end

  // Registered display digits, colon and second pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      d3       <= 4'd0;
      d2       <= 4'd0;
      d1       <= 4'd0;
      d0       <= 4'd0;
      colon    <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick_c;
      case (md)
        SET_ALARM: {d3, d2, d1, d0} <= {ahh, amm};
        RUN_MS:    {d3, d2, d1, d0} <= {mm, ss};
        default:   {d3, d2, d1, d0} <= {hh, mm};
      endcase
      if (run_mode_c)
        colon <= (cnt < HALF);
      else
        colon <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core with TICKS_PER_SEC=4, ALARM_LEN_SEC=3.
module tb_clock_time_core;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] mode;
  logic       min_up, hour_up, alarm_en;
  logic [3:0] d3, d2, d1, d0;
  logic       colon, sec_tick, alarm;

  int vectors = 0;
  int miscompares = 0;
  int ticks = 0;

  clock_time_core #(.TICKS_PER_SEC(4), .ALARM_LEN_SEC(3)) dut (
    .clk(clk), .clr(clr), .mode(mode), .min_up(min_up), .hour_up(hour_up),
    .alarm_en(alarm_en), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .colon(colon), .sec_tick(sec_tick), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sec_tick) ticks++;
    end
  endtask

  task automatic do_reset();
    clr = 1'b1; min_up = 1'b0; hour_up = 1'b0; alarm_en = 1'b0; mode = 2'd0;
    step(2);
    clr = 1'b0;
  endtask

  // n pulses on a button: hi cycles high, lo cycles low
  task automatic pulse(input bit is_hour, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      if (is_hour) hour_up = 1'b1; else min_up = 1'b1;
      step(hi);
      if (is_hour) hour_up = 1'b0; else min_up = 1'b0;
      step(lo);
    end
  endtask

  function automatic int digits();
    return int'({d3, d2, d1, d0});
  endfunction

  // Reset, set alarm to 00:02 without losing a second, run until alarm rises
  task automatic fire_alarm(input string tag);
    int steps;
    do_reset();
    mode = 2'd2;
    min_up = 1'b1; step(1);
    min_up = 1'b0; step(1);
    min_up = 1'b1; step(1);
    min_up = 1'b0; alarm_en = 1'b1; mode = 2'd0;
    ticks = 0;
    steps = 0;
    while (!alarm && steps < 600) begin
      step(1);
      steps++;
    end
    chk({tag, "_rise_cycle"}, steps, 478);
    chk({tag, "_ticks_at_rise"}, ticks, 120);
    chk({tag, "_digits_at_rise"}, digits(), 16'h0002);
  endtask

  initial begin
    int dur;

    // 1. reset state and free run
    do_reset();
    clr = 1'b1; step(1); clr = 1'b0;
    chk("rst_digits", digits(), 0);
    chk("rst_colon", int'(colon), 0);
    chk("rst_sec_tick", int'(sec_tick), 0);
    chk("rst_alarm", int'(alarm), 0);
    ticks = 0;
    step(240);
    chk("run_ticks", ticks, 60);
    step(1);
    chk("run_digits_hm", digits(), 16'h0001);
    mode = 2'd3;
    step(1);
    chk("run_digits_ms", digits(), 16'h0100);
    chk("run_colon_lo_half", int'(colon), 1);
    step(1);
    chk("run_colon_hi_half", int'(colon), 0);

    // 2. set 23:59 then roll over to 00:00
    do_reset();
    mode = 2'd1;
    ticks = 0;
    pulse(1'b1, 23, 2, 2);
    pulse(1'b0, 59, 2, 2);
    chk("set_no_ticks", ticks, 0);
    chk("set_digits", digits(), 16'h2359);
    chk("set_colon", int'(colon), 1);
    mode = 2'd0;
    step(237);
    chk("roll_pre_digits", digits(), 16'h2359);
    step(4);
    chk("roll_digits", digits(), 16'h0000);
    chk("roll_ticks", ticks, 60);

    // 3. both buttons held together
    do_reset();
    mode = 2'd1;
    min_up = 1'b1; hour_up = 1'b1;
    step(10);
    min_up = 1'b0; hour_up = 1'b0;
    step(2);
    chk("held_digits", digits(), 16'h0101);

    // 4. alarm fires and times out after 3 seconds
    fire_alarm("afire");
    dur = 0;
    while (alarm && dur < 50) begin
      dur++;
      step(1);
    end
    chk("afire_duration", dur, 12);

    // 5a. dismiss by button in run mode
    fire_alarm("adism");
    min_up = 1'b1; step(1); min_up = 1'b0;
    chk("adism_alarm", int'(alarm), 0);
    chk("adism_digits", digits(), 16'h0002);

    // 5b. disarm by alarm_en
    fire_alarm("adis");
    alarm_en = 1'b0; step(1);
    chk("adis_alarm", int'(alarm), 0);
    chk("adis_digits", digits(), 16'h0002);

    // 6. reset in the middle of an adjust
    do_reset();
    mode = 2'd2;
    pulse(1'b1, 1, 1, 2);
    chk("mid_alarm_reg", digits(), 16'h0100);
    mode = 2'd1;
    pulse(1'b1, 5, 1, 1);
    step(1);
    chk("mid_set_digits", digits(), 16'h0500);
    hour_up = 1'b1; clr = 1'b1;
    step(1);
    hour_up = 1'b0; clr = 1'b0;
    chk("mid_rst_digits", digits(), 0);
    chk("mid_rst_alarm", int'(alarm), 0);
    chk("mid_rst_sec_tick", int'(sec_tick), 0);
    chk("mid_rst_colon", int'(colon), 0);
    mode = 2'd2;
    step(2);
    chk("mid_rst_alarm_reg", digits(), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
Time-keeping and alarm engine for the digital alarm clock. It sits directly upstream of the 7-segment display multiplexer. It keeps HH:MM:SS in BCD and holds an alarm HH:MM register. It applies min_up/hour_up adjustments according to mode, and drives the four BCD display digits, the colon and the alarm output consumed by the display and buzzer stages.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per second; benches override it to 4.
ALARM_LEN_SEC, 60, seconds that alarm stays asserted if not dismissed.

Ports:
clk  input  1  system clock; all logic on rising edge
clr  input  1  synchronous active-high reset
mode  input  2  0=RUN show HH:MM, 1=SET_TIME, 2=SET_ALARM show alarm HH:MM, 3=RUN show MM:SS
min_up  input  1  minute-advance button, level, already debounced/synchronized upstream
hour_up  input  1  hour-advance button, same conditioning as min_up
alarm_en  input  1  arms the alarm compare
d3  output  4  leftmost BCD digit
d2  output  4  BCD digit
d1  output  4  BCD digit
d0  output  4  rightmost BCD digit
colon  output  1  colon segment enable
sec_tick  output  1  one-cycle pulse per elapsed second
alarm  output  1  alarm active

Behaviour:
- Reset (clr=1 at a clk edge): time 00:00:00, alarm register 00:00, prescaler 0, button history 0. All outputs 0 the following cycle. clr overrides every other input, including mid-adjust and mid-alarm.
- Prescaler: counts 0..TICKS_PER_SEC-1. sec_tick=1 for one cycle when the count is at its terminal value, then the count wraps to 0.
- Prescaler in SET_TIME: held at 0, so no sec_tick. In all other modes it runs.
- Edge detect: rise = in & ~prev, where prev is a registered copy of the input.
  - One increment per rising edge; a held button never repeats.
  - A button high at the first cycle after reset counts as an edge.
- Time advance (modes 0, 2, 3): on sec_tick, seconds +1. Carry 59->00 into minutes, minutes 59->00 into hours, hours 23->00. 23:59:59 -> 00:00:00.
- SET_TIME:
  - min_up edge: minutes +1, wraps 59->00 with no carry to hours; seconds cleared to 00.
  - hour_up edge: hours +1, wraps 23->00.
  - Both edges in the same cycle: both increments apply.
- SET_ALARM: same edge rules applied to the alarm register. Time keeps running.
- RUN modes 0/3: min_up/hour_up edges do not change time or the alarm register.
- Alarm trigger:
  - Condition: alarm_en=1, mode≠1, and a sec_tick produces a time whose HH:MM equals the alarm register with seconds=00.
  - alarm rises one cycle after that sec_tick.
- Alarm deassertion, whichever comes first:
  - ALARM_LEN_SEC sec_ticks after assertion;
  - alarm_en=0, deasserted the next cycle;
  - any min_up/hour_up rising edge in mode 0 or 3 (dismiss), deasserted the next cycle with time unchanged.
  - Entering SET_TIME does not clear an active alarm.
- Display (registered, 1-cycle latency from state change):
  - mode 0/1: d3..d0 = H1 H0 M1 M0.
  - mode 2: alarm register AH1 AH0 AM1 AM0.
  - mode 3: M1 M0 S1 S0.
- colon:
  - modes 1/2: constant 1.
  - modes 0/3: 1 while prescaler < TICKS_PER_SEC/2, else 0.
- BCD digits are never outside 0-9; hours tens digit never exceeds 2.
- Mode change: takes effect the next cycle and never alters time or the alarm register by itself.

Test Plan:
All scenarios use TICKS_PER_SEC=4, ALARM_LEN_SEC=3.
1. Free run: clr 2 cycles, mode=0, run 240 cycles -> 60 sec_tick pulses, d3..d0=0,0,0,1. Then mode=3 -> d3..d0=0,1,0,0 next cycle.
2. Rollover: mode=1, 23 hour_up pulses (2 high/2 low each), 59 min_up pulses -> 23:59. Then mode=0 and 60 sec_ticks -> d3..d0=0,0,0,0. Confirm no sec_tick while in mode 1.
3. Simultaneous/held buttons: from reset, mode=1, min_up and hour_up high together for 10 cycles then low -> display 0,1,0,1. Exactly one increment each.
4. Alarm fire/timeout: mode=2, two min_up edges -> alarm 00:02, alarm_en=1. Then mode=0 from 00:00:00. alarm rises one cycle after the 120th sec_tick, stays high 12 cycles (3 sec_ticks), falls.
5. Dismiss/disarm: repeat 4. A min_up edge while alarm=1 -> alarm=0 next cycle, time digits unchanged. Repeat with alarm_en dropped instead -> same.
6. Reset mid-operation: mode=1 after 5 hour_up edges, assert clr one cycle during a button-high cycle -> next cycle d3..d0=0, alarm=0, sec_tick=0, colon=0. The alarm register reads 00:00 in mode 2.
